// File: rtl/branch_pc_unit_pkg.sv
// Shared constants for the branch/PC unit: funct3 codes, FSM encoding, fetch step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_pc_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Flush counter width; covers FLUSH_CYCLES up to 7.
  localparam int CNT_W = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_pc_unit_branch_decide.sv
// Branch condition decode: funct3 + comparator flags -> taken/illegal, plus BrUn select.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are.
module branch_decide
  import branch_pc_unit_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_lt_i,
  input  logic       br_eq_i,
  output logic       br_un_o,
  output logic       taken_o,
  output logic       illegal_o
);

  // Unsigned compare is selected by funct3[1] (BLTU/BGEU); 010/011 also set it but are illegal anyway.
  assign br_un_o = funct3_i[1];

  // Map funct3 to the comparator flag it depends on; 010/011 never take.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:           taken_o = br_eq_i;
      F3_BNE:           taken_o = ~br_eq_i;
      F3_BLT, F3_BLTU:  taken_o = br_lt_i;
      F3_BGE, F3_BGEU:  taken_o = ~br_lt_i;
      default:          illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC owner: resolves EX branches/jumps (predict-not-taken), redirects and flushes IF/ID.
// Latency: redirect target on pc one cycle after taken; flush held FLUSH_CYCLES cycles.
// Backpressure: stall holds pc except when a redirect lands; stall never pauses the flush count.
// Optional: define BRANCH_STATS_EN to add br_total/br_taken conditional-branch counters.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        BrLT,
  input  logic        BrEQ,
  output logic        BrUn,
  output logic [31:0] pc,
  output logic        taken,
  output logic        redirect,
  output logic        flush,
  output logic        illegal_br,
  output logic        misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_total,
  output logic [31:0] br_taken
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic             illegal_q, illegal_d;
  logic             misalign_q, misalign_d;

  logic             br_cond;
  logic             br_illegal;
  logic             ex_live;
  logic [31:0]      target;
  logic             redir_go;

  branch_decide u_decide (
    .funct3_i  (ex_funct3),
    .br_lt_i   (BrLT),
    .br_eq_i   (BrEQ),
    .br_un_o   (BrUn),
    .taken_o   (br_cond),
    .illegal_o (br_illegal)
  );

  // EX contents are wrong-path while flushing, so only trust them in RUN.
  assign ex_live = ex_valid & (state_q == ST_RUN);

  // Target adder and taken resolution; JALR clears bit 0 of its sum.
  always_comb begin
    if (ex_is_jalr && !ex_is_branch && !ex_is_jal) begin
      target = (ex_rs1 + ex_imm) & ~32'h1;
    end else begin
      target = ex_pc + ex_imm;
    end
    taken    = ex_live & (ex_is_branch ? br_cond : (ex_is_jal | ex_is_jalr));
    redir_go = taken & ~target[1];
  end

  // FSM next state: enter FLUSH on an aligned redirect, count down, then return to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (redir_go) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath next state: redirect beats stall, stall beats sequential fetch.
  always_comb begin
    if (redir_go) begin
      pc_d = target;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
    redirect_d = redir_go;
    illegal_d  = ex_live & ex_is_branch & br_illegal;
    misalign_d = misalign_q | (taken & target[1]);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc         = pc_q;
  assign redirect   = redirect_q;
  assign flush      = (state_q == ST_FLUSH);
  assign illegal_br = illegal_q;
  assign misalign   = misalign_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] total_q;
  logic [31:0] taken_cnt_q;
  logic        br_resolved;

  assign br_resolved = ex_live & ex_is_branch;

  // Conditional-branch counters; taken count includes misaligned targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q     <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (br_resolved) begin
        total_q <= total_q + 32'd1;
      end
      if (br_resolved & br_cond) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign br_total = total_q;
  assign br_taken = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        BrLT;
  logic        BrEQ;
  logic        BrUn;
  logic [31:0] pc;
  logic        taken;
  logic        redirect;
  logic        flush;
  logic        illegal_br;
  logic        misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_total;
  logic [31:0] br_taken;
`endif

  int n_checks = 0;
  int n_errors = 0;

  branch_pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_is_jal    (ex_is_jal),
    .ex_is_jalr   (ex_is_jalr),
    .ex_funct3    (ex_funct3),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .BrLT         (BrLT),
    .BrEQ         (BrEQ),
    .BrUn         (BrUn),
    .pc           (pc),
    .taken        (taken),
    .redirect     (redirect),
    .flush        (flush),
    .illegal_br   (illegal_br),
    .misalign     (misalign)
`ifdef BRANCH_STATS_EN
    ,
    .br_total     (br_total),
    .br_taken     (br_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 3'b000; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; BrLT = 0; BrEQ = 0;
  endtask

  initial begin
    rst = 1; stall = 0;
    clear_ex();
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_redirect", {31'b0, redirect}, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    tick(); tick();
    rst = 0;
    check("run_pc0", pc, 32'h0);
    tick(); check("run_pc4", pc, 32'h4);
    tick(); check("run_pc8", pc, 32'h8);

    // Combinational decode checks (no edge in between).
    ex_valid = 1; ex_is_branch = 1;
    ex_funct3 = 3'b001; BrEQ = 1; #1;
    check("bne_eq", {31'b0, taken}, 32'h0);
    ex_funct3 = 3'b100; BrLT = 1; BrEQ = 0; #1;
    check("blt_lt", {31'b0, taken}, 32'h1);
    check("blt_brun", {31'b0, BrUn}, 32'h0);
    ex_funct3 = 3'b110; #1;
    check("bltu_brun", {31'b0, BrUn}, 32'h1);
    ex_valid = 0; #1;
    check("novalid_taken", {31'b0, taken}, 32'h0);
    check("novalid_brun", {31'b0, BrUn}, 32'h1);
    clear_ex(); #1;

    // BEQ taken; inputs left asserted during flush must be ignored.
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000;
    ex_pc = 32'h100; ex_imm = 32'h20; BrEQ = 1; #1;
    check("beq_taken", {31'b0, taken}, 32'h1);
    tick();
    check("beq_pc", pc, 32'h120);
    check("beq_redirect", {31'b0, redirect}, 32'h1);
    check("beq_flush1", {31'b0, flush}, 32'h1);
    check("flush_taken_masked", {31'b0, taken}, 32'h0);
    tick();
    check("beq_flush2", {31'b0, flush}, 32'h1);
    check("beq_pc_flush", pc, 32'h124);
    check("beq_redirect_pulse", {31'b0, redirect}, 32'h0);
    clear_ex();
    tick();
    check("beq_flush_end", {31'b0, flush}, 32'h0);
    check("beq_pc_after", pc, 32'h128);

    // BGEU: not taken with BrLT=1, taken with BrLT=0.
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b111;
    ex_pc = 32'h300; ex_imm = 32'h10; BrLT = 1; #1;
    check("bgeu_brun", {31'b0, BrUn}, 32'h1);
    check("bgeu_nt", {31'b0, taken}, 32'h0);
    tick();
    check("bgeu_nt_pc", pc, 32'h12C);
    check("bgeu_nt_redir", {31'b0, redirect}, 32'h0);
    BrLT = 0; #1;
    tick();
    check("bgeu_t_pc", pc, 32'h310);
    check("bgeu_t_redir", {31'b0, redirect}, 32'h1);
    clear_ex();
    tick(); tick();
    check("bgeu_pc_after", pc, 32'h318);
    check("bgeu_flush_end", {31'b0, flush}, 32'h0);

    // Illegal funct3 010.
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b010; BrEQ = 1; BrLT = 1; #1;
    check("ill_taken", {31'b0, taken}, 32'h0);
    tick();
    check("ill_pulse", {31'b0, illegal_br}, 32'h1);
    check("ill_pc", pc, 32'h31C);
    clear_ex();
    tick();
    check("ill_pulse_end", {31'b0, illegal_br}, 32'h0);
    check("ill_pc2", pc, 32'h320);
`ifdef BRANCH_STATS_EN
    check("stat_total", br_total, 32'd4);
    check("stat_taken", br_taken, 32'd2);
`endif

    // JALR misaligned, then aligned.
    ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h203; ex_imm = 0; #1;
    check("jalr_mis_taken", {31'b0, taken}, 32'h1);
    tick();
    check("jalr_mis_redir", {31'b0, redirect}, 32'h0);
    check("jalr_mis_flag", {31'b0, misalign}, 32'h1);
    check("jalr_mis_pc", pc, 32'h324);
    ex_rs1 = 32'h201; #1;
    tick();
    check("jalr_pc", pc, 32'h200);
    check("jalr_redir", {31'b0, redirect}, 32'h1);
    check("misalign_sticky", {31'b0, misalign}, 32'h1);
    clear_ex();
    tick(); tick();
    check("jalr_pc_after", pc, 32'h208);

    // Redirect beats stall; stall does not pause the flush counter.
    stall = 1; ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h400; ex_imm = 32'h40; #1;
    tick();
    check("stall_redir_pc", pc, 32'h440);
    check("stall_redir", {31'b0, redirect}, 32'h1);
    clear_ex();
    tick();
    check("stall_hold_pc", pc, 32'h440);
    tick();
    check("stall_flush_end", {31'b0, flush}, 32'h0);
    tick();
    check("stall_hold_pc2", pc, 32'h440);
    stall = 0;

    // Wrap 0xFFFF_FFFC -> 0.
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC; #1;
    tick();
    check("wrap_target", pc, 32'hFFFF_FFFC);
    clear_ex();
    tick();
    check("wrap_pc0", pc, 32'h0);

    // Reset mid-flush with pc=0x40.
    tick();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h40; ex_imm = 0; #1;
    tick();
    check("pre_rst_pc", pc, 32'h40);
    check("pre_rst_flush", {31'b0, flush}, 32'h1);
    clear_ex();
    rst = 1; #1;
    check("arst_pc", pc, 32'h0);
    check("arst_flush", {31'b0, flush}, 32'h0);
    check("arst_misalign", {31'b0, misalign}, 32'h0);
    tick();
    rst = 0;
    tick(); check("post_rst_pc4", pc, 32'h4);
    tick(); check("post_rst_pc8", pc, 32'h8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Consumer side of the branch comparator. Drives BrUn to the comparator, takes back BrLT/BrEQ, and resolves branches and jumps in EX.
- Owns the fetch PC register and generates the redirect and flush of wrong-path instructions.
- Static predict-not-taken: fetch runs at PC+4 until EX resolves a taken control transfer.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset
FLUSH_CYCLES, 2, number of cycles flush stays asserted after a redirect (range 1..7)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard stall; holds the fetch PC
ex_valid  input  1  EX-stage instruction is valid
ex_is_branch  input  1  EX instruction is a conditional branch
ex_is_jal  input  1  EX instruction is JAL
ex_is_jalr  input  1  EX instruction is JALR
ex_funct3  input  3  branch funct3
ex_pc  input  32  PC of the EX instruction
ex_imm  input  32  sign-extended immediate
ex_rs1  input  32  rs1 value (JALR base)
BrLT  input  1  comparator less-than result
BrEQ  input  1  comparator equal result
BrUn  output  1  unsigned-compare select to the comparator
pc  output  32  fetch PC (registered)
taken  output  1  EX control transfer resolves taken (combinational)
redirect  output  1  one-cycle pulse, registered, a redirect occurred
flush  output  1  kill IF/ID instructions
illegal_br  output  1  one-cycle pulse, registered, branch with funct3 010 or 011
misalign  output  1  sticky flag, taken target has bit[1] set

Behaviour:
- Reset (asynchronous, any cycle, including mid-flush) sets:
  - pc = RESET_PC
  - redirect, flush, illegal_br, misalign = 0
  - state = RUN, flush counter = 0
- BrUn = ex_funct3[1]. Purely combinational; valid even when ex_valid = 0.
- Branch decode by funct3:
  - 000 BEQ: taken = BrEQ
  - 001 BNE: taken = !BrEQ
  - 100 BLT and 110 BLTU: taken = BrLT
  - 101 BGE and 111 BGEU: taken = !BrLT
  - 010 and 011: taken = 0, and illegal_br pulses on the next cycle
- JAL and JALR are always taken.
- taken is qualified by ex_valid and by state = RUN. It is forced to 0 during FLUSH.
- Target computation (32-bit, wraps modulo 2^32, no overflow flag):
  - Branch and JAL: ex_pc + ex_imm
  - JALR: (ex_rs1 + ex_imm) & ~32'h1
- Misaligned target: if taken and target[1] = 1, then no redirect occurs, misalign sets and stays set until rst, and pc follows normal stall/+4 rules.
- Each rising edge, in priority order:
  1. taken and aligned: pc <= target, redirect <= 1, state <= FLUSH, counter <= FLUSH_CYCLES-1. Overrides stall.
  2. stall: pc holds.
  3. otherwise: pc <= pc + 4 (wraps 32'hFFFF_FFFC to 0).
- Latency: the redirect target appears on pc one cycle after taken. redirect is high in that same cycle.
- State machine:
  - RUN to FLUSH on an aligned taken resolution.
  - FLUSH: flush = 1, and EX inputs are ignored because they are wrong-path.
  - Counter decrements each cycle; FLUSH returns to RUN when the counter reaches 0. flush is high for exactly FLUSH_CYCLES cycles.
  - stall during FLUSH still holds pc but does not pause the counter.
- Multiple control instructions with ex_valid = 0 have no effect, except BrUn.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds outputs br_total[31:0] and br_taken[31:0]. Both reset to 0, wrap at 2^32.
  - br_total increments once per resolved conditional branch in RUN (ex_valid & ex_is_branch, including illegal funct3).
  - br_taken increments once per taken conditional branch, including misaligned ones.
  - JAL and JALR are not counted.
- Not defined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - state encoding ST_RUN, ST_FLUSH
  - PC_STEP = 4
- One natural sub-module, branch_decide: combinational funct3/BrLT/BrEQ to taken/illegal decision plus BrUn.
- Target adder and the sequential logic stay in the top module.

Test Plan:
- Reset: assert rst mid-flush with pc=0x40 -> pc=RESET_PC immediately, flush=0. After release, pc advances 0,4,8.
- BEQ with funct3=000, ex_pc=0x100, imm=0x20, BrEQ=1 -> taken=1. Next cycle pc=0x120 and redirect=1. flush high for exactly 2 cycles. EX taken inputs are ignored during those cycles.
- BGEU with funct3=111 -> BrUn=1. With BrLT=1, not taken, pc continues +4. With BrLT=0, pc=ex_pc+imm.
- JALR with rs1=0x203, imm=0 -> pc=0x202, which is misaligned, so no redirect, misalign=1 and sticky. Then rs1=0x201 -> pc=0x200 and redirect=1.
- Taken branch with stall=1 in the same cycle -> redirect wins and pc=target. Stall alone with no redirect -> pc holds. pc=0xFFFF_FFFC unstalled -> 0.
- funct3=010 with ex_is_branch=1 -> taken=0 and illegal_br pulses one cycle. With BRANCH_STATS_EN: br_total increments, br_taken does not.
